// File: rtl/e1_tx_hdb3_if.sv
// ---------------------------------------------------------------------------
// e1_tx_hdb3_if
// Bus between the E1 TX framer side and the HDB3/AMI line coder.
//   in_bit     framer NRZ data bit (1 = mark)
//   in_valid   single-cycle bit strobe from the framer
//   ctrl_hdb3  1 = HDB3 substitution, 0 = plain AMI
//   out_pos    positive mark pulse towards the TX PHY
//   out_neg    negative mark pulse towards the TX PHY
//   out_valid  one-cycle strobe: a new line symbol starts this cycle
//   stat_viol  one-cycle pulse: the symbol starting now is a V
// master: framer / stimulus side.  slave: the line coder.
// ---------------------------------------------------------------------------
interface e1_tx_hdb3_if;
  logic in_bit;
  logic in_valid;
  logic ctrl_hdb3;
  logic out_pos;
  logic out_neg;
  logic out_valid;
  logic stat_viol;

  modport master (
    output in_bit, in_valid, ctrl_hdb3,
    input  out_pos, out_neg, out_valid, stat_viol
  );

  modport slave (
    input  in_bit, in_valid, ctrl_hdb3,
    output out_pos, out_neg, out_valid, stat_viol
  );
endinterface

// File: rtl/e1_tx_pulse.sv
// ---------------------------------------------------------------------------
// e1_tx_pulse
// Per-symbol pulse shaper. On start, drives out_pos (pol = 0) or out_neg
// (pol = 1) high for PULSE_W cycles when mark is set; a space leaves both
// low. A new start during an active pulse replaces it with no gap.
//   clk, rst   clock, asynchronous active-high reset
//   start      begin a new symbol this cycle
//   pol        polarity of the symbol (1 = negative)
//   mark       symbol is a mark (otherwise space)
//   out_pos    positive mark pulse
//   out_neg    negative mark pulse
// ---------------------------------------------------------------------------
module e1_tx_pulse #(
  parameter int PULSE_W = 8,
  parameter int PW_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pol,
  input  logic mark,
  output logic out_pos,
  output logic out_neg
);
  logic               pos_reg;
  logic               neg_reg;
  logic [PW_BITS-1:0] cnt_reg;

  // cnt_reg holds the number of further cycles the pulse stays high after
  // the current one, so loading PULSE_W-1 yields exactly PULSE_W high cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg <= 1'b0;
      neg_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (start) begin
      pos_reg <= mark & ~pol;
      neg_reg <= mark & pol;
      cnt_reg <= PW_BITS'(PULSE_W - 1);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end else begin
      pos_reg <= 1'b0;
      neg_reg <= 1'b0;
    end
  end

  assign out_pos = pos_reg;
  assign out_neg = neg_reg;
endmodule

// File: rtl/e1_tx_hdb3.sv
// ---------------------------------------------------------------------------
// e1_tx_hdb3
// E1 transmit line coder: takes the framer's NRZ bit stream and produces
// bipolar HDB3 (or AMI) mark pulses for the TX PHY. A 4-symbol look-ahead
// pipeline lets a B pulse be inserted in front of a four-zero run.
//   clk, rst   clock, asynchronous active-high reset
//   bus        e1_tx_hdb3_if.slave: in_bit/in_valid/ctrl_hdb3 in,
//              out_pos/out_neg/out_valid/stat_viol out
// Latency: the bit of strobe n leaves the pipeline on strobe n+4; the line
// pulse starts one clk after that strobe.
// ---------------------------------------------------------------------------
module e1_tx_hdb3 #(
  parameter int PULSE_W = 8,
  parameter int PW_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  e1_tx_hdb3_if.slave  bus
);
  // Symbol = {mark, is_v}
  localparam int         MARK    = 1;
  localparam int         IS_V    = 0;
  localparam logic [1:0] SYM_B   = 2'b10;
  localparam logic [1:0] SYM_V   = 2'b11;

  logic [3:0][1:0] pipe_reg, pipe_next;   // [0] newest, [3] oldest
  logic [1:0]      zcnt_reg, zcnt_next;
  logic            parity_reg, parity_next;
  logic            last_neg_reg, last_neg_next;
  logic            valid_reg;
  logic            viol_reg;

  logic out_mark;
  logic out_v;
  logic out_pol;

  assign out_mark = pipe_reg[3][MARK];
  assign out_v    = pipe_reg[3][IS_V];
  // A V repeats the previous mark polarity; any other mark (B included)
  // alternates.
  assign out_pol  = out_v ? last_neg_reg : ~last_neg_reg;

  always_comb begin
    pipe_next     = pipe_reg;
    zcnt_next     = zcnt_reg;
    parity_next   = parity_reg;
    last_neg_next = last_neg_reg;
    if (bus.in_valid) begin
      pipe_next[3] = pipe_reg[2];
      pipe_next[2] = pipe_reg[1];
      pipe_next[1] = pipe_reg[0];
      pipe_next[0] = {bus.in_bit, 1'b0};
      if (out_mark)
        last_neg_next = out_pol;

      if (bus.in_bit) begin
        zcnt_next   = 2'd0;
        parity_next = ~parity_reg;
      end else if (!bus.ctrl_hdb3) begin
        zcnt_next = 2'd0;
      end else if (zcnt_reg != 2'd3) begin
        zcnt_next = zcnt_reg + 2'd1;
      end else begin
        // Fourth zero: stages 0..2 hold the three earlier zeros, so after
        // the shift the run occupies new stages 3..0. Even mark count since
        // the last V needs a B at the head of the run to keep V alternating.
        pipe_next[0] = SYM_V;
        if (!parity_reg)
          pipe_next[3] = SYM_B;
        zcnt_next   = 2'd0;
        parity_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_reg     <= '0;
      zcnt_reg     <= 2'd0;
      parity_reg   <= 1'b0;
      last_neg_reg <= 1'b1;   // first mark after reset goes positive
      valid_reg    <= 1'b0;
      viol_reg     <= 1'b0;
    end else begin
      pipe_reg     <= pipe_next;
      zcnt_reg     <= zcnt_next;
      parity_reg   <= parity_next;
      last_neg_reg <= last_neg_next;
      valid_reg    <= bus.in_valid;
      viol_reg     <= bus.in_valid & out_v;
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.stat_viol = viol_reg;

  e1_tx_pulse #(
    .PULSE_W (PULSE_W),
    .PW_BITS (PW_BITS)
  ) u_pulse (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.in_valid),
    .pol     (out_pol),
    .mark    (out_mark),
    .out_pos (bus.out_pos),
    .out_neg (bus.out_neg)
  );
endmodule
